// File: rtl/stage_execute.sv
// ---------------------------------------------------------------------------
// stage_execute
//
// Execute stage of the in-order RV32 pipeline. Computes single-cycle RV32I
// ALU results and runs MUL / MULHU on an iterative shift-add multiplier,
// then presents the result plus the pass-through control fields to
// stage_memory through one registered boundary.
//
// Ports:
//   i_Clock, i_Reset      rising-edge clock, async active-high reset
//   i_Valid, i_Flush      upstream instruction valid / branch-redirect kill
//   i_AluOp               operation select (0..11 defined, 12..15 give 0)
//   i_OperandA/B          ALU operands
//   i_Rs2Value, i_Rd, i_MemWrite, i_RegWrite, i_WritebackSrc
//                         fields carried through to stage_memory
//   o_Stall               combinational hold request to upstream
//   o_Valid, o_AluOutput, o_Rs2Value, o_Rd, o_MemWrite, o_RegWrite,
//   o_WritebackSrc        registered outputs toward stage_memory
//   o_DebugState          current FSM state (0 = IDLE, 1 = MUL_BUSY)
//
// Handshake: upstream presents an instruction with i_Valid=1. It is
// consumed at a rising edge where i_Valid=1 and o_Stall=0 (and i_Flush=0).
// While o_Stall=1 upstream must hold every input stable. There is no
// backpressure from stage_memory; a registered o_Valid is always accepted.
// ---------------------------------------------------------------------------
module stage_execute #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Valid,
  input  logic            i_Flush,
  input  logic [3:0]      i_AluOp,
  input  logic [XLEN-1:0] i_OperandA,
  input  logic [XLEN-1:0] i_OperandB,
  input  logic [XLEN-1:0] i_Rs2Value,
  input  logic [4:0]      i_Rd,
  input  logic            i_MemWrite,
  input  logic            i_RegWrite,
  input  logic            i_WritebackSrc,
  output logic            o_Stall,
  output logic            o_Valid,
  output logic [XLEN-1:0] o_AluOutput,
  output logic [XLEN-1:0] o_Rs2Value,
  output logic [4:0]      o_Rd,
  output logic            o_MemWrite,
  output logic            o_RegWrite,
  output logic            o_WritebackSrc,
  output logic            o_DebugState
);

  localparam int MUL_CYCLES = XLEN / MUL_STEP;
  localparam int CW         = $clog2(MUL_CYCLES);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } execState_t;

  execState_t state;

  logic [CW-1:0]     mulCount;
  logic [XLEN-1:0]   mulA;      // remaining multiplier bits, LSB first
  logic [2*XLEN-1:0] mulB;      // multiplicand, pre-shifted to current weight
  logic [2*XLEN-1:0] accum;
  logic              mulHigh;   // 1 = MULHU (return upper half)

  logic [XLEN-1:0]   heldRs2;
  logic [4:0]        heldRd;
  logic              heldMemWrite;
  logic              heldRegWrite;
  logic              heldWbSrc;

  logic              isMulOp;
  logic              lastStep;
  logic [2*XLEN-1:0] stepSum;
  logic [2*XLEN-1:0] accumNext;
  logic [XLEN-1:0]   aluResult;

  assign isMulOp      = (i_AluOp == 4'd10) || (i_AluOp == 4'd11);
  assign lastStep     = (mulCount == CW'(MUL_CYCLES - 1));
  assign o_DebugState = state;

  // Stall covers the accept cycle and every busy cycle except the last;
  // flush and reset always release upstream.
  always_comb begin
    o_Stall = 1'b0;
    if (!i_Reset && !i_Flush) begin
      if (state == IDLE) o_Stall = i_Valid && isMulOp;
      else               o_Stall = !lastStep;
    end
  end

  // One shift-add step: add the multiplicand for each of the MUL_STEP
  // multiplier bits retired this cycle.
  always_comb begin
    stepSum = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mulA[j]) stepSum = stepSum + (mulB << j);
    end
    accumNext = accum + stepSum;
  end

  always_comb begin
    aluResult = '0;
    case (i_AluOp)
      4'd0: aluResult = i_OperandA + i_OperandB;
      4'd1: aluResult = i_OperandA - i_OperandB;
      4'd2: aluResult = i_OperandA << i_OperandB[4:0];
      4'd3: aluResult = {{(XLEN-1){1'b0}}, $signed(i_OperandA) < $signed(i_OperandB)};
      4'd4: aluResult = {{(XLEN-1){1'b0}}, i_OperandA < i_OperandB};
      4'd5: aluResult = i_OperandA ^ i_OperandB;
      4'd6: aluResult = i_OperandA >> i_OperandB[4:0];
      4'd7: aluResult = XLEN'($signed(i_OperandA) >>> i_OperandB[4:0]);
      4'd8: aluResult = i_OperandA | i_OperandB;
      4'd9: aluResult = i_OperandA & i_OperandB;
      default: aluResult = '0;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= IDLE;
      mulCount       <= '0;
      mulA           <= '0;
      mulB           <= '0;
      accum          <= '0;
      mulHigh        <= 1'b0;
      heldRs2        <= '0;
      heldRd         <= '0;
      heldMemWrite   <= 1'b0;
      heldRegWrite   <= 1'b0;
      heldWbSrc      <= 1'b0;
      o_Valid        <= 1'b0;
      o_AluOutput    <= '0;
      o_Rs2Value     <= '0;
      o_Rd           <= '0;
      o_MemWrite     <= 1'b0;
      o_RegWrite     <= 1'b0;
      o_WritebackSrc <= 1'b0;
    end else begin
      // Bubble by default; the branches below override when a result retires.
      o_Valid        <= 1'b0;
      o_AluOutput    <= '0;
      o_Rs2Value     <= '0;
      o_Rd           <= '0;
      o_MemWrite     <= 1'b0;
      o_RegWrite     <= 1'b0;
      o_WritebackSrc <= 1'b0;

      if (i_Flush) begin
        state    <= IDLE;
        mulCount <= '0;
        accum    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_Valid && isMulOp) begin
              state        <= MUL_BUSY;
              mulCount     <= '0;
              mulA         <= i_OperandA;
              mulB         <= {{XLEN{1'b0}}, i_OperandB};
              accum        <= '0;
              mulHigh      <= (i_AluOp == 4'd11);
              heldRs2      <= i_Rs2Value;
              heldRd       <= i_Rd;
              heldMemWrite <= i_MemWrite;
              heldRegWrite <= i_RegWrite;
              heldWbSrc    <= i_WritebackSrc;
            end else if (i_Valid) begin
              o_Valid        <= 1'b1;
              o_AluOutput    <= aluResult;
              o_Rs2Value     <= i_Rs2Value;
              o_Rd           <= i_Rd;
              o_MemWrite     <= i_MemWrite;
              o_RegWrite     <= i_RegWrite;
              o_WritebackSrc <= i_WritebackSrc;
            end
          end
          MUL_BUSY: begin
            mulA     <= mulA >> MUL_STEP;
            mulB     <= mulB << MUL_STEP;
            accum    <= accumNext;
            mulCount <= mulCount + 1'b1;
            if (lastStep) begin
              state          <= IDLE;
              o_Valid        <= 1'b1;
              o_AluOutput    <= mulHigh ? accumNext[2*XLEN-1:XLEN] : accumNext[XLEN-1:0];
              o_Rs2Value     <= heldRs2;
              o_Rd           <= heldRd;
              o_MemWrite     <= heldMemWrite;
              o_RegWrite     <= heldRegWrite;
              o_WritebackSrc <= heldWbSrc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
